// File: rtl/i2c_wd_ctrl.sv
// I2C bus-stall watchdog: sequences the ring-oscillator warm-up, then trips
// hif_watchdog when SCL stays idle for wd_timeout cycles during an ACTIVE transfer.
module i2c_wd_ctrl #(
  parameter int CNT_W      = 16,
  parameter int WARMUP_CYC = 8
) (
  input  logic             sys_clk,
  input  logic             rst,
  input  logic             i2c_wd_en_n,
  input  logic             hif_select,
  input  logic             hif_active,
  input  logic             hif_scl,
  input  logic [CNT_W-1:0] wd_timeout,
  output logic             slow_clk_en,
  output logic             hif_watchdog,
  output logic             wd_irq,
  output logic [2:0]       wd_state
);

  typedef enum logic [2:0] {
    S_OFF   = 3'd0,
    S_WARM  = 3'd1,
    S_IDLE  = 3'd2,
    S_COUNT = 3'd3,
    S_TRIP  = 3'd4
  } state_t;

  localparam logic [7:0]       WARM_LD = 8'(WARMUP_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [7:0]       warm_cnt;
  logic [CNT_W-1:0] cnt;
  logic             active_p0, active_p1;
  logic             scl_p0, scl_p1, scl_p2;
  logic             en;
  logic             active_s;
  logic             scl_edge;

  // A zero timeout would otherwise underflow on the first decrement.
  function automatic logic [CNT_W-1:0] load_val(input logic [CNT_W-1:0] t);
    return (t == '0) ? CNT_ONE : t;
  endfunction

  assign en       = ~i2c_wd_en_n & ~hif_select;
  assign active_s = active_p1;
  assign scl_edge = scl_p1 ^ scl_p2;

  // Stage p0/p1: two-flop synchronizers; p2: SCL history for edge detection
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      active_p0 <= 1'b0;
      active_p1 <= 1'b0;
      scl_p0    <= 1'b0;
      scl_p1    <= 1'b0;
      scl_p2    <= 1'b0;
    end else begin
      active_p0 <= hif_active;
      active_p1 <= active_p0;
      scl_p0    <= hif_scl;
      scl_p1    <= scl_p0;
      scl_p2    <= scl_p1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state    <= S_OFF;
      warm_cnt <= '0;
      cnt      <= '0;
      wd_irq   <= 1'b0;
    end else begin
      wd_irq <= 1'b0;
      if (!en) begin
        state <= S_OFF;
      end else begin
        case (state)
          S_OFF: begin
            state    <= S_WARM;
            warm_cnt <= WARM_LD;
          end
          S_WARM: begin
            if (warm_cnt <= 8'd1) state <= S_IDLE;
            else                  warm_cnt <= warm_cnt - 8'd1;
          end
          S_IDLE: begin
            if (active_s) begin
              state <= S_COUNT;
              cnt   <= load_val(wd_timeout);
            end
          end
          S_COUNT: begin
            if (!active_s) begin
              state <= S_IDLE;
            end else if (scl_edge) begin
              cnt <= load_val(wd_timeout);
            end else if (cnt <= CNT_ONE) begin
              state  <= S_TRIP;
              wd_irq <= 1'b1;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          S_TRIP: begin
            if (!active_s) state <= S_IDLE;
          end
          default: state <= S_OFF;
        endcase
      end
    end
  end

  assign slow_clk_en  = (state != S_OFF);
  assign hif_watchdog = (state == S_TRIP);
  assign wd_state     = state;

endmodule
